// File: rtl/ibis_scanout_arbiter.sv
// Framebuffer port arbiter: row prefetch into a ping-pong line buffer, interleaved host access.
// Define IBIS_SCANOUT_UNDERRUN_CNT_EN to add the saturating underrun_count output.

module ibis_scanout_arbiter #(
    parameter int WORDS_PER_LINE  = 80,
    parameter int V_ACTIVE        = 480,
    parameter int V_TOTAL         = 525,
    parameter int ADDR_W          = 17,
    parameter int DATA_W          = 64,
    parameter int BASE_ADDR       = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int HOST_EVERY      = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic              line_start,
    input  logic [11:0]       line_y,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [6:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              underrun
`ifdef IBIS_SCANOUT_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FAIR_W = $clog2(HOST_EVERY + 1);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
    logic [6:0]          word_q, word_d;
    logic                bank_q, bank_d;
    logic                epoch_q, epoch_d;
    logic                underrun_q, underrun_d;
    logic [FAIR_W-1:0]   fair_q, fair_d;
    logic                lock_q, lock_d;
    logic                lock_src_q, lock_src_d;
    logic [CNT_W-1:0]    scan_cur_q, scan_cur_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;

    logic                tag_src_q [MAX_OUTSTANDING];
    logic                tag_ep_q  [MAX_OUTSTANDING];
    logic [6:0]          tag_idx_q [MAX_OUTSTANDING];

    logic                lb_we_q, lb_bank_q, host_rvalid_q;
    logic [6:0]          lb_addr_q;
    logic [DATA_W-1:0]   lb_wdata_q, host_rdata_q;

    logic [12:0]         r;
    logic [ADDR_W-1:0]   row_base;
    logic                line_go, ur_event;
    logic                sel_host, slots_free, grant, host_take, scan_gnt;
    logic                push, pop, pop_src, pop_ep, pop_cur_scan;
    logic [6:0]          pop_idx;
    logic [CNT_W-1:0]    scan_left;

    // Target row: the row after line_y, wrapping to 0 after the last total row.
    assign r        = (line_y == 12'(V_TOTAL - 1)) ? 13'd0 : ({1'b0, line_y} + 13'd1);
    assign row_base = ADDR_W'(BASE_ADDR) + ADDR_W'(r) * ADDR_W'(WORDS_PER_LINE);
    assign line_go  = line_start && enable && (r < 13'(V_ACTIVE));

    // A presented-but-ungranted request keeps its source; otherwise scan wins unless host is owed a slot.
    assign sel_host   = lock_q ? lock_src_q
                               : ((state_q == S_IDLE) || (host_req && (fair_q == FAIR_W'(HOST_EVERY))));
    assign slots_free = (fcnt_q < CNT_W'(MAX_OUTSTANDING));

    assign mem_req   = enable && (sel_host ? (host_req && (host_we || slots_free))
                                           : ((state_q == S_SCAN) && slots_free));
    assign mem_we    = mem_req && sel_host && host_we;
    assign mem_addr  = mem_req ? (sel_host ? host_addr : scan_addr_q) : '0;
    assign mem_wdata = mem_we ? host_wdata : '0;

    assign grant     = mem_req && mem_gnt;
    assign host_take = grant && sel_host;
    assign scan_gnt  = grant && !sel_host;
    assign host_gnt  = host_take;

    assign push         = grant && !mem_we;
    assign pop          = mem_rvalid && (fcnt_q != '0);
    assign pop_src      = tag_src_q[rd_ptr_q];
    assign pop_ep       = tag_ep_q[rd_ptr_q];
    assign pop_idx      = tag_idx_q[rd_ptr_q];
    assign pop_cur_scan = pop && !pop_src && (pop_ep == epoch_q);

    // A read completing in the same cycle as the line pulse does not count against the fetch.
    assign scan_left = scan_cur_q - CNT_W'(pop_cur_scan);
    assign ur_event  = line_go && ((state_q == S_SCAN) || (scan_left != '0));

    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        word_d      = word_q;
        bank_d      = bank_q;
        epoch_d     = epoch_q;
        underrun_d  = underrun_q;
        fair_d      = fair_q;
        lock_d      = lock_q;
        lock_src_d  = lock_src_q;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        fcnt_d      = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        scan_cur_d  = scan_cur_q + CNT_W'(scan_gnt) - CNT_W'(pop_cur_scan);

        if (grant) begin
            lock_d = 1'b0;
        end else if (mem_req) begin
            lock_d     = 1'b1;
            lock_src_d = sel_host;
        end

        if (host_take) begin
            fair_d = '0;
        end else if (scan_gnt) begin
            if (!host_req) begin
                fair_d = '0;
            end else if (fair_q != FAIR_W'(HOST_EVERY)) begin
                fair_d = fair_q + FAIR_W'(1);
            end
        end

        if (scan_gnt) begin
            word_d      = word_q + 7'd1;
            scan_addr_d = scan_addr_q + ADDR_W'(1);
            if (word_q + 7'd1 == 7'(WORDS_PER_LINE)) begin
                state_d = S_IDLE;
            end
        end

        // A new row always takes over; a late one retires the old epoch so stale returns are dropped.
        if (line_go) begin
            state_d     = S_SCAN;
            scan_addr_d = row_base;
            word_d      = 7'd0;
            bank_d      = r[0];
            if (ur_event) begin
                underrun_d = 1'b1;
                epoch_d    = ~epoch_q;
                scan_cur_d = '0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            scan_addr_q <= '0;
            word_q      <= '0;
            bank_q      <= 1'b0;
            epoch_q     <= 1'b0;
            underrun_q  <= 1'b0;
            fair_q      <= '0;
            lock_q      <= 1'b0;
            lock_src_q  <= 1'b0;
            scan_cur_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            scan_addr_q <= scan_addr_d;
            word_q      <= word_d;
            bank_q      <= bank_d;
            epoch_q     <= epoch_d;
            underrun_q  <= underrun_d;
            fair_q      <= fair_d;
            lock_q      <= lock_d;
            lock_src_q  <= lock_src_d;
            scan_cur_q  <= scan_cur_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            tag_src_q[wr_ptr_q] <= sel_host;
            tag_ep_q[wr_ptr_q]  <= epoch_q;
            tag_idx_q[wr_ptr_q] <= word_q;
        end
    end

    // Return routing stage: one cycle after mem_rvalid.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lb_we_q       <= 1'b0;
            lb_bank_q     <= 1'b0;
            lb_addr_q     <= '0;
            lb_wdata_q    <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            lb_we_q       <= pop_cur_scan;
            host_rvalid_q <= pop && pop_src;
            if (pop_cur_scan) begin
                lb_bank_q  <= bank_q;
                lb_addr_q  <= pop_idx;
                lb_wdata_q <= mem_rdata;
            end
            if (pop && pop_src) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign lb_we       = lb_we_q;
    assign lb_bank     = lb_bank_q;
    assign lb_addr     = lb_addr_q;
    assign lb_wdata    = lb_wdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign underrun    = underrun_q;

`ifdef IBIS_SCANOUT_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ucnt_q <= '0;
        end else if (ur_event && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_ibis_scanout_arbiter.sv
// Directed bench for ibis_scanout_arbiter with an in-order memory responder (3-cycle read latency).

module tb_ibis_scanout_arbiter;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic        line_start = 1'b0;
    logic [11:0] line_y = '0;
    logic        mem_req, mem_we;
    logic [16:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [16:0] host_addr = '0;
    logic [63:0] host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [63:0] host_rdata;
    logic        lb_we, lb_bank;
    logic [6:0]  lb_addr;
    logic [63:0] lb_wdata;
    logic        underrun;
`ifdef IBIS_SCANOUT_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    ibis_scanout_arbiter dut (
        .aclk(aclk), .areset(areset), .enable(enable),
        .line_start(line_start), .line_y(line_y),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .underrun(underrun)
`ifdef IBIS_SCANOUT_UNDERRUN_CNT_EN
        , .underrun_count(underrun_count)
`endif
    );

    always #5 aclk = ~aclk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int a);
        logic [31:0] w;
        w = 32'(a);
        return {32'hA5A5_0000 ^ w, w * 32'd3 + 32'd7};
    endfunction

    // Logs filled at each falling edge by the responder process.
    logic [16:0] g_addr  [2048];
    logic        g_we    [2048];
    logic        g_host  [2048];
    logic [63:0] g_wdata [2048];
    logic [6:0]  l_addr  [2048];
    logic        l_bank  [2048];
    logic [63:0] l_data  [2048];
    logic [63:0] h_data  [16];
    int g_n = 0, l_n = 0, h_n = 0;
    int cyc = 0;
    logic rv_block = 1'b0;
    logic [63:0] rq_data [$];
    int          rq_due  [$];

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
            #1;
            if (areset) begin
                rq_data.delete();
                rq_due.delete();
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end else if (!rv_block && rq_due.size() > 0 && rq_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rq_data.pop_front();
                void'(rq_due.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            @(negedge aclk);
            if (!areset) begin
                if (mem_req && mem_gnt && g_n < 2048) begin
                    g_addr[g_n] = mem_addr; g_we[g_n] = mem_we;
                    g_host[g_n] = host_gnt; g_wdata[g_n] = mem_wdata;
                    g_n++;
                    if (!mem_we) begin
                        rq_data.push_back(pat(int'(mem_addr)));
                        rq_due.push_back(cyc + 3);
                    end
                end
                if (lb_we && l_n < 2048) begin
                    l_addr[l_n] = lb_addr; l_bank[l_n] = lb_bank; l_data[l_n] = lb_wdata;
                    l_n++;
                end
                if (host_rvalid && h_n < 16) begin
                    h_data[h_n] = host_rdata;
                    h_n++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse(input int y);
        line_y     = 12'(y);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_lb(input int target, input string tag);
        int k = 0;
        while (l_n < target && k < 400) begin
            tick();
            k++;
        end
        check_vec(tag, 64'(l_n >= target), 64'd1);
    endtask

    // Checks a completed row of 80 words; host grants in the grant log are skipped.
    task automatic check_row(input string tag, input int lbb, input int gbb, input int row, input logic bank);
        int j = gbb;
        check_vec({tag, "_bank"}, 64'(l_bank[lbb]), 64'(bank));
        for (int i = 0; i < 80; i++) begin
            check_vec($sformatf("%s_lbaddr[%0d]", tag, i), 64'(l_addr[lbb + i]), 64'(i));
            check_vec($sformatf("%s_lbdata[%0d]", tag, i), l_data[lbb + i], pat(row * 80 + i));
            while (j < g_n - 1 && g_host[j]) j++;
            check_vec($sformatf("%s_gaddr[%0d]", tag, i), 64'(g_addr[j]), 64'(row * 80 + i));
            j++;
        end
    endtask

    int gb, lb, hb, hi;
    logic seen;

    initial begin
        // Reset values
        tick();
        @(negedge aclk);
        check_vec("rst_mem_req", 64'(mem_req), 64'd0);
        check_vec("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_vec("rst_host_gnt", 64'(host_gnt), 64'd0);
        check_vec("rst_lb_we", 64'(lb_we), 64'd0);
        check_vec("rst_host_rvalid", 64'(host_rvalid), 64'd0);
        check_vec("rst_underrun", 64'(underrun), 64'd0);
        tick();
        areset = 1'b0;
        enable = 1'b1;
        mem_gnt = 1'b1;
        tick();

        // Row fetch: line 9 -> row 10 at 800..879, bank 0
        gb = g_n; lb = l_n;
        @(negedge aclk);
        check_vec("t1_req_before", 64'(mem_req), 64'd0);
        tick();
        pulse(9);
        @(negedge aclk);
        check_vec("t1_first_req", 64'(mem_req), 64'd1);
        check_vec("t1_first_addr", 64'(mem_addr), 64'd800);
        wait_lb(lb + 80, "t1_done");
        repeat (5) tick();
        check_vec("t1_ngrants", 64'(g_n - gb), 64'd80);
        check_vec("t1_nlb", 64'(l_n - lb), 64'd80);
        check_row("t1", lb, gb, 10, 1'b0);
        check_vec("t1_underrun", 64'(underrun), 64'd0);

        // Last-line wrap and last visible row
        gb = g_n; lb = l_n;
        pulse(524);
        @(negedge aclk);
        check_vec("t2_wrap_addr", 64'(mem_addr), 64'd0);
        wait_lb(lb + 80, "t2_wrap_done");
        repeat (5) tick();
        check_row("t2w", lb, gb, 0, 1'b0);
        gb = g_n; lb = l_n;
        pulse(478);
        @(negedge aclk);
        check_vec("t2_last_addr", 64'(mem_addr), 64'd38320);
        wait_lb(lb + 80, "t2_last_done");
        repeat (5) tick();
        check_row("t2l", lb, gb, 479, 1'b1);
        gb = g_n;
        pulse(479);
        repeat (5) tick();
        @(negedge aclk);
        check_vec("t2_blank_req", 64'(mem_req), 64'd0);
        check_vec("t2_blank_grants", 64'(g_n - gb), 64'd0);
        check_vec("t2_underrun", 64'(underrun), 64'd0);

        // Fairness: host held high during a scan of row 1
        tick();
        gb = g_n; lb = l_n; hb = h_n;
        pulse(0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 17'h1F000; host_wdata = '0;
        hi = 0; seen = 1'b0;
        for (int k = 0; k < 400 && !(l_n >= lb + 80 && hi >= 3); k++) begin
            @(negedge aclk);
            if (host_req && host_gnt) seen = 1'b1;
            tick();
            if (seen) begin
                seen = 1'b0;
                hi++;
                if (hi == 1) begin
                    host_we = 1'b1; host_addr = 17'h1F001; host_wdata = 64'h0123_4567_89AB_CDEF;
                end else if (hi == 2) begin
                    host_we = 1'b0; host_addr = 17'h00005; host_wdata = '0;
                end else begin
                    host_req = 1'b0; host_we = 1'b0; host_addr = '0;
                end
            end
        end
        repeat (6) tick();
        check_vec("t3_hosts", 64'(hi), 64'd3);
        check_vec("t3_ngrants", 64'(g_n - gb), 64'd83);
        check_vec("t3_h0_pos", 64'(g_host[gb + 8]), 64'd1);
        check_vec("t3_h0_addr", 64'(g_addr[gb + 8]), 64'h1F000);
        check_vec("t3_h1_pos", 64'(g_host[gb + 17]), 64'd1);
        check_vec("t3_h1_we", 64'(g_we[gb + 17]), 64'd1);
        check_vec("t3_h1_wdata", g_wdata[gb + 17], 64'h0123_4567_89AB_CDEF);
        check_vec("t3_h2_pos", 64'(g_host[gb + 26]), 64'd1);
        check_vec("t3_h2_addr", 64'(g_addr[gb + 26]), 64'h00005);
        check_vec("t3_scan_pos7", 64'(g_host[gb + 7]), 64'd0);
        check_vec("t3_nrdata", 64'(h_n - hb), 64'd2);
        check_vec("t3_rdata0", h_data[hb], pat(32'h1F000));
        check_vec("t3_rdata1", h_data[hb + 1], pat(5));
        check_vec("t3_nlb", 64'(l_n - lb), 64'd80);
        check_row("t3", lb, gb, 1, 1'b1);
        check_vec("t3_underrun", 64'(underrun), 64'd0);

        // Underrun with no grants, then outstanding limit, then a stale-return underrun
        mem_gnt = 1'b0;
        pulse(10);
        repeat (3) tick();
        @(negedge aclk);
        check_vec("t4_pend_req", 64'(mem_req), 64'd1);
        check_vec("t4_pend_addr", 64'(mem_addr), 64'd880);
        check_vec("t4_no_underrun", 64'(underrun), 64'd0);
        tick();
        pulse(11);
        @(negedge aclk);
        check_vec("t4_underrun", 64'(underrun), 64'd1);
        check_vec("t4_new_addr", 64'(mem_addr), 64'd960);
        tick();
        rv_block = 1'b1;
        mem_gnt  = 1'b1;
        gb = g_n; lb = l_n;
        repeat (10) tick();
        @(negedge aclk);
        check_vec("t4_limit_grants", 64'(g_n - gb), 64'd4);
        check_vec("t4_limit_req", 64'(mem_req), 64'd0);
        check_vec("t4_limit_a0", 64'(g_addr[gb]), 64'd960);
        check_vec("t4_limit_a3", 64'(g_addr[gb + 3]), 64'd963);
        tick();
        pulse(12);
        repeat (2) tick();
        rv_block = 1'b0;
        wait_lb(lb + 80, "t4_done");
        repeat (10) tick();
        check_vec("t4_nlb", 64'(l_n - lb), 64'd80);
        check_vec("t4_ngrants", 64'(g_n - gb), 64'd84);
        check_row("t4", lb, gb + 4, 13, 1'b1);
        check_vec("t4_underrun_sticky", 64'(underrun), 64'd1);
`ifdef IBIS_SCANOUT_UNDERRUN_CNT_EN
        check_vec("t4_underrun_count", 64'(underrun_count), 64'd2);
`endif

        // Reset during SCAN
        pulse(19);
        repeat (10) tick();
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        check_vec("t5_rst_mem_req", 64'(mem_req), 64'd0);
        check_vec("t5_rst_mem_addr", 64'(mem_addr), 64'd0);
        check_vec("t5_rst_lb_we", 64'(lb_we), 64'd0);
        check_vec("t5_rst_lb_addr", 64'(lb_addr), 64'd0);
        check_vec("t5_rst_host_rvalid", 64'(host_rvalid), 64'd0);
        check_vec("t5_rst_underrun", 64'(underrun), 64'd0);
        repeat (2) tick();
        #2 areset = 1'b0;
        gb = g_n; lb = l_n;
        repeat (6) tick();
        @(negedge aclk);
        check_vec("t5_post_grants", 64'(g_n - gb), 64'd0);
        check_vec("t5_post_lb", 64'(l_n - lb), 64'd0);
        check_vec("t5_post_underrun", 64'(underrun), 64'd0);
`ifdef IBIS_SCANOUT_UNDERRUN_CNT_EN
        check_vec("t5_post_count", 64'(underrun_count), 64'd0);
`endif

        // Enable low: no issue, line pulses ignored
        tick();
        enable = 1'b0;
        pulse(9);
        repeat (4) tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00100;
        tick();
        @(negedge aclk);
        check_vec("t5_dis_req", 64'(mem_req), 64'd0);
        check_vec("t5_dis_host_gnt", 64'(host_gnt), 64'd0);
        check_vec("t5_dis_grants", 64'(g_n - gb), 64'd0);
        tick();
        host_req = 1'b0; host_addr = '0;
        enable = 1'b1;
        repeat (2) tick();
        @(negedge aclk);
        check_vec("t5_ignored_pulse", 64'(mem_req), 64'd0);
        tick();
        gb = g_n; lb = l_n;
        pulse(9);
        @(negedge aclk);
        check_vec("t5_re_addr", 64'(mem_addr), 64'd800);
        wait_lb(lb + 80, "t5_done");
        repeat (5) tick();
        check_row("t5", lb, gb, 10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
